miv_rv32_ecc_tpram: RTL and testbench

Parametrised two-port (1W/1R) RAM with in-fabric SECDED protection, the successor to the fixed 128x21 ECC RAM used for core L1 tag/data arrays. It encodes on write and decodes/corrects on read. Single-bit errors are scrubbed by a write-back that is deferred until the write port is idle. Error counters and a last-error address are kept for the core's error CSRs.

---
 rtl/miv_rv32_ecc_pkg.sv | 16 +
 rtl/miv_rv32_secded_codec.sv | 50 +++++
 rtl/miv_rv32_ecc_tpram.sv | 135 +++++++++++++
 tb/tb_miv_rv32_ecc_tpram.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/miv_rv32_ecc_pkg.sv
// miv_rv32_ecc_pkg: SECDED code geometry helpers and scrub FSM state type.
package miv_rv32_ecc_pkg;

    function automatic int ecc_check_bits(int data_width);
        int p = 1;
        while ((1 << p) < data_width + p + 1) p++;
        return p;
    endfunction

    function automatic int code_width(int data_width);
        return data_width + ecc_check_bits(data_width) + 1;
    endfunction

    typedef enum logic {S_IDLE, S_PEND} scrub_state_e;

endpackage

// File: rtl/miv_rv32_secded_codec.sv
// miv_rv32_secded_codec: combinational Hamming+parity encoder and decoder.
// Bit 0 is overall parity; bits 1..CW-1 are Hamming positions, check bits at powers of two.
module miv_rv32_secded_codec
    import miv_rv32_ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 21,
    localparam int P = ecc_check_bits(DATA_WIDTH),
    localparam int CW = DATA_WIDTH + P + 1
) (
    input  logic [DATA_WIDTH-1:0] enc_data,
    output logic [CW-1:0]         enc_code,
    input  logic [CW-1:0]         dec_code,
    output logic [DATA_WIDTH-1:0] dec_data,
    output logic [DATA_WIDTH-1:0] dec_raw,
    output logic                  dec_sb,
    output logic                  dec_db
);

    logic [CW-1:1] dpl;
    logic [P-1:0]  hs, syn;
    logic          par_err;

    always_comb begin
        hs = '0;
        syn = '0;
        for (int i = 1; i < CW; i++) begin
            if (dpl[i]) hs = hs ^ P'(i);
            if (dec_code[i]) syn = syn ^ P'(i);
        end
    end

    assign par_err = ^dec_code;
    assign dec_sb = par_err;
    assign dec_db = !par_err && |syn;
    assign enc_code[0] = ^{enc_data, hs};

    // data index of position i is i minus the count of powers of two up to i, minus one
    for (genvar i = 1; i < CW; i++) begin : g_pos
        if ((i & (i - 1)) == 0) begin : g_chk
            assign dpl[i] = 1'b0;
            assign enc_code[i] = hs[$clog2(i)];
        end else begin : g_dat
            assign dpl[i] = enc_data[i - $clog2(i + 1) - 1];
            assign enc_code[i] = dpl[i];
            assign dec_raw[i - $clog2(i + 1) - 1] = dec_code[i];
            assign dec_data[i - $clog2(i + 1) - 1] = dec_code[i] ^ (par_err && syn == P'(i));
        end
    end

endmodule

// File: rtl/miv_rv32_ecc_tpram.sv
// miv_rv32_ecc_tpram: 1W/1R SECDED-protected RAM with deferred scrub write-back
// and saturating error counters.
module miv_rv32_ecc_tpram
    import miv_rv32_ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 21,
    parameter int ADDR_WIDTH = 7,
    parameter int OUT_PIPE = 0,
    parameter int SCRUB_EN = 1,
    parameter int CNT_WIDTH = 8,
    localparam int CODE_W = code_width(DATA_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  WEN,
    input  logic [ADDR_WIDTH-1:0] WADDR,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic [CODE_W-1:0]     INJ_MASK,
    input  logic                  REN,
    input  logic [ADDR_WIDTH-1:0] RADDR,
    input  logic                  ECC_EN,
    input  logic                  CNT_CLR,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  RD_VALID,
    output logic                  SB_CORRECT,
    output logic                  DB_DETECT,
    output logic [CNT_WIDTH-1:0]  SB_COUNT,
    output logic [CNT_WIDTH-1:0]  DB_COUNT,
    output logic [ADDR_WIDTH-1:0] ERR_ADDR,
    output logic                  BUSY
);

    logic [CODE_W-1:0]     mem [2**ADDR_WIDTH];
    logic [CODE_W-1:0]     rcode, enc_code;
    logic [DATA_WIDTH-1:0] enc_data, dec_data, dec_raw, scrub_data, d1;
    logic [ADDR_WIDTH-1:0] raddr1, scrub_addr, out_addr;
    logic                  rvalid1, dec_sb, dec_db, sb1, db1, scrub_go;
    scrub_state_e          state;

    // scrub only ever writes when the host port is idle, so one encoder serves both
    assign scrub_go = state == S_PEND && !WEN;
    assign enc_data = WEN ? WD : scrub_data;
    assign BUSY = state == S_PEND;

    always_ff @(posedge CLK) begin
        if (WEN || scrub_go) mem[WEN ? WADDR : scrub_addr] <= enc_code ^ (WEN ? INJ_MASK : '0);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            rvalid1 <= 1'b0;
            rcode <= '0;
            raddr1 <= '0;
        end else begin
            rvalid1 <= REN;
            if (REN) begin
                rcode <= mem[RADDR];
                raddr1 <= RADDR;
            end
        end
    end

    miv_rv32_secded_codec #(.DATA_WIDTH(DATA_WIDTH)) u_codec (
        .enc_data (enc_data),
        .enc_code (enc_code),
        .dec_code (rcode),
        .dec_data (dec_data),
        .dec_raw  (dec_raw),
        .dec_sb   (dec_sb),
        .dec_db   (dec_db)
    );

    assign sb1 = rvalid1 && ECC_EN && dec_sb;
    assign db1 = rvalid1 && ECC_EN && dec_db;
    assign d1 = ECC_EN ? dec_data : dec_raw;

    if (OUT_PIPE != 0) begin : g_pipe
        always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
                RD <= '0;
                RD_VALID <= 1'b0;
                SB_CORRECT <= 1'b0;
                DB_DETECT <= 1'b0;
                out_addr <= '0;
            end else begin
                RD <= d1;
                RD_VALID <= rvalid1;
                SB_CORRECT <= sb1;
                DB_DETECT <= db1;
                out_addr <= raddr1;
            end
        end
    end else begin : g_direct
        assign RD = d1;
        assign RD_VALID = rvalid1;
        assign SB_CORRECT = sb1;
        assign DB_DETECT = db1;
        assign out_addr = raddr1;
    end

    // a host write to the flagged address in the same cycle makes the corrected word stale
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= S_IDLE;
            scrub_addr <= '0;
            scrub_data <= '0;
        end else if (state == S_IDLE) begin
            if (SB_CORRECT && SCRUB_EN != 0 && !(WEN && WADDR == out_addr)) begin
                state <= S_PEND;
                scrub_addr <= out_addr;
                scrub_data <= RD;
            end
        end else if (!WEN || WADDR == scrub_addr) begin
            state <= S_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            SB_COUNT <= '0;
            DB_COUNT <= '0;
            ERR_ADDR <= '0;
        end else begin
            if (CNT_CLR) begin
                SB_COUNT <= '0;
                DB_COUNT <= '0;
            end else begin
                if (SB_CORRECT && !(&SB_COUNT)) SB_COUNT <= SB_COUNT + 1'b1;
                if (DB_DETECT && !(&DB_COUNT)) DB_COUNT <= DB_COUNT + 1'b1;
            end
            if (SB_CORRECT || DB_DETECT) ERR_ADDR <= out_addr;
        end
    end

endmodule

// File: tb/tb_miv_rv32_ecc_tpram.sv
// tb_miv_rv32_ecc_tpram: directed checks of the ECC RAM, with a second
// OUT_PIPE=1 instance sharing the inputs for latency and reset checks.
module tb_miv_rv32_ecc_tpram;

    logic        clk = 1'b0;
    logic        rst_n, wen, ren, ecc_en, cnt_clr;
    logic [6:0]  waddr, raddr;
    logic [20:0] wd;
    logic [26:0] inj;
    logic [20:0] rd, rd2;
    logic        rd_valid, sb, db, busy, rd_valid2, sb2, db2, busy2;
    logic [7:0]  sbc, dbc, sbc2, dbc2;
    logic [6:0]  ea, ea2;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    miv_rv32_ecc_tpram dut (
        .CLK(clk), .RESETN(rst_n), .WEN(wen), .WADDR(waddr), .WD(wd), .INJ_MASK(inj),
        .REN(ren), .RADDR(raddr), .ECC_EN(ecc_en), .CNT_CLR(cnt_clr),
        .RD(rd), .RD_VALID(rd_valid), .SB_CORRECT(sb), .DB_DETECT(db),
        .SB_COUNT(sbc), .DB_COUNT(dbc), .ERR_ADDR(ea), .BUSY(busy)
    );

    miv_rv32_ecc_tpram #(.OUT_PIPE(1)) dut2 (
        .CLK(clk), .RESETN(rst_n), .WEN(wen), .WADDR(waddr), .WD(wd), .INJ_MASK(inj),
        .REN(ren), .RADDR(raddr), .ECC_EN(ecc_en), .CNT_CLR(cnt_clr),
        .RD(rd2), .RD_VALID(rd_valid2), .SB_CORRECT(sb2), .DB_DETECT(db2),
        .SB_COUNT(sbc2), .DB_COUNT(dbc2), .ERR_ADDR(ea2), .BUSY(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [20:0] d, input logic [26:0] m);
        wen = 1'b1;
        waddr = a;
        wd = d;
        inj = m;
        tick;
        wen = 1'b0;
        inj = '0;
    endtask

    task automatic rdx(input logic [6:0] a);
        ren = 1'b1;
        raddr = a;
        tick;
        ren = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wen = 1'b0; ren = 1'b0; ecc_en = 1'b1; cnt_clr = 1'b0;
        waddr = '0; raddr = '0; wd = '0; inj = '0;
        repeat (2) tick;
        chk("rst_rd", 32'(rd), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_sb", 32'(sb), 0);
        chk("rst_db", 32'(db), 0);
        chk("rst_sbc", 32'(sbc), 0);
        chk("rst_dbc", 32'(dbc), 0);
        chk("rst_ea", 32'(ea), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst2_rd", 32'(rd2), 0);
        chk("rst2_flags", 32'({rd_valid2, sb2, db2, busy2}), 0);
        chk("rst2_cnt", 32'({sbc2, dbc2, ea2}), 0);
        rst_n = 1'b1;
        tick;

        wr(7'd5, 21'h155555, '0);
        rdx(7'd5);
        chk("basic_valid", 32'(rd_valid), 1);
        chk("basic_rd", 32'(rd), 32'h155555);
        chk("basic_flags", 32'({sb, db}), 0);
        chk("pipe_lat1", 32'(rd_valid2), 0);
        tick;
        chk("basic_valid_drop", 32'(rd_valid), 0);
        chk("pipe_valid", 32'(rd_valid2), 1);
        chk("pipe_rd", 32'(rd2), 32'h155555);
        chk("basic_sbc", 32'(sbc), 0);
        tick;
        chk("pipe_valid_drop", 32'(rd_valid2), 0);

        wr(7'd9, 21'h0ABCDE, 27'h8);
        rdx(7'd9);
        chk("sb_rd", 32'(rd), 32'h0ABCDE);
        chk("sb_flag", 32'(sb), 1);
        chk("sb_nodb", 32'(db), 0);
        tick;
        chk("sb_count", 32'(sbc), 1);
        chk("sb_erraddr", 32'(ea), 9);
        chk("sb_busy", 32'(busy), 1);
        chk("sb_flag_gated", 32'(sb), 0);
        tick;
        chk("sb_scrubbed", 32'(busy), 0);
        rdx(7'd9);
        chk("sb_reread_rd", 32'(rd), 32'h0ABCDE);
        chk("sb_reread_flags", 32'({sb, db}), 0);
        tick;

        wr(7'd12, 21'h1F0F0F, 27'h404);
        rdx(7'd12);
        chk("db_flag", 32'(db), 1);
        chk("db_nosb", 32'(sb), 0);
        chk("db_raw", 32'(rd), 32'h1F0F2F);
        tick;
        chk("db_count", 32'(dbc), 1);
        chk("db_erraddr", 32'(ea), 12);
        chk("db_nobusy", 32'(busy), 0);

        wr(7'd20, 21'h012345, 27'h20);
        rdx(7'd20);
        chk("wait_sb", 32'(sb), 1);
        wen = 1'b1; waddr = 7'd30; wd = '0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("wait_busy", 32'(busy), 1);
        end
        wen = 1'b0;
        tick;
        chk("wait_done", 32'(busy), 0);
        rdx(7'd20);
        chk("wait_reread_rd", 32'(rd), 32'h012345);
        chk("wait_reread_sb", 32'(sb), 0);
        tick;

        wr(7'd40, 21'h0AAAAA, 27'h40);
        rdx(7'd40);
        chk("cancel_sb", 32'(sb), 1);
        chk("cancel_rd", 32'(rd), 32'h0AAAAA);
        wen = 1'b1; waddr = 7'd50; wd = '0;
        tick;
        chk("cancel_busy", 32'(busy), 1);
        waddr = 7'd40; wd = 21'h033333;
        tick;
        chk("cancel_idle", 32'(busy), 0);
        wen = 1'b0;
        repeat (2) tick;
        rdx(7'd40);
        chk("cancel_host_rd", 32'(rd), 32'h033333);
        chk("cancel_host_flags", 32'({sb, db}), 0);
        tick;

        wr(7'd60, 21'h000111, 27'h8);
        ecc_en = 1'b0;
        rdx(7'd60);
        chk("raw_valid", 32'(rd_valid), 1);
        chk("raw_rd", 32'(rd), 32'h000110);
        chk("raw_flags", 32'({sb, db}), 0);
        tick;
        ecc_en = 1'b1;
        chk("raw_nobusy", 32'(busy), 0);
        chk("raw_sbc", 32'(sbc), 3);

        wr(7'd61, 21'h1ABCDE, 27'h1);
        rdx(7'd61);
        chk("par_sb", 32'(sb), 1);
        chk("par_rd", 32'(rd), 32'h1ABCDE);
        tick;
        chk("par_sbc", 32'(sbc), 4);
        chk("par_erraddr", 32'(ea), 61);
        tick;

        rdx(7'd60);
        chk("clr_sb", 32'(sb), 1);
        cnt_clr = 1'b1;
        tick;
        cnt_clr = 1'b0;
        chk("clr_sbc", 32'(sbc), 0);
        chk("clr_dbc", 32'(dbc), 0);
        tick;

        wr(7'd70, 21'h0F0F0F, 27'h8);
        wen = 1'b1; waddr = 7'd71; wd = '0;
        ren = 1'b1; raddr = 7'd70;
        repeat (300) tick;
        ren = 1'b0;
        tick;
        chk("sat_sbc", 32'(sbc), 255);
        chk("sat_busy", 32'(busy), 1);

        ren = 1'b1; raddr = 7'd5;
        tick;
        ren = 1'b0;
        chk("rst_mid_pre", 32'(rd_valid), 1);
        rst_n = 1'b0;
        wen = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(rd_valid), 0);
        chk("rst_mid_rd", 32'(rd), 0);
        chk("rst_mid_sbc", 32'(sbc), 0);
        chk("rst_mid_ea", 32'(ea), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_valid2", 32'(rd_valid2), 0);
        tick;
        chk("rst_inflight2", 32'(rd_valid2), 0);
        rst_n = 1'b1;
        tick;
        chk("rst_after2", 32'(rd_valid2), 0);
        chk("rst_scrub_dropped", 32'(busy), 0);
        rdx(7'd70);
        chk("rst_scrub_lost_sb", 32'(sb), 1);
        chk("rst_scrub_lost_rd", 32'(rd), 32'h0F0F0F);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
